cfg_loader: RTL and testbench

Bit-serial configuration loader for the switch-block fabric. It accepts the configuration bitstream through a valid/ready handshake and assembles it into 18-bit frames (9 horizontal plus 9 vertical dot-control bits). It then writes each frame into one switch block with a one-cycle write-enable pulse, in block order 0..NUM_BLK-1. It sits directly upstream of the switch-block array and drives the array's shared `bits` bus and the per-block `wr_en` lines.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/cfg_crc8.sv | 29 ++
 rtl/cfg_loader.sv | 214 +++++++++++++++++++++
 tb/tb_cfg_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants, state encoding and the CRC-8 step helper
// for the bit-serial configuration loader.
package cfg_pkg;

  localparam int         FRAME_W        = 18;
  localparam logic [7:0] CFG_CRC_POLY   = 8'h07;
  localparam logic [4:0] LAST_FRAME_BIT = 5'd17;  // bit counter value of the 18th frame bit
  localparam logic [4:0] LAST_CRC_BIT   = 5'd7;   // bit counter value of the 8th CRC bit

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WRITE = 3'd2,
    ST_CRC   = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_e;

  // One step of an MSB-first CRC-8 (poly CFG_CRC_POLY) over a single bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d);
    logic fb;
    fb = crc[7] ^ d;
    if (fb) begin
      crc8_step = {crc[6:0], 1'b0} ^ CFG_CRC_POLY;
    end else begin
      crc8_step = {crc[6:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8: bit-serial CRC-8 remainder with synchronous clear and enable.
// Only instantiated by cfg_loader when CFG_LOADER_CRC_EN is defined.
module cfg_crc8 import cfg_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_data,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  // Remainder register: clear wins over a data step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_data);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: bit-serial configuration loader. Shifts FRAME_W-bit frames in
// over a valid/ready handshake and writes them to switch blocks 0..NUM_BLK-1
// with a one-cycle one-hot wr_en pulse. Optional trailing CRC-8 check is
// enabled by defining CFG_LOADER_CRC_EN; without it err is tied to 0.
module cfg_loader import cfg_pkg::*; #(
  parameter int NUM_BLK = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_data,
  output logic               cfg_ready,
  output logic [FRAME_W-1:0] bits,
  output logic [NUM_BLK-1:0] wr_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int             IDX_W    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLK - 1);

  cfg_state_e         r_state;
  cfg_state_e         w_state_nxt;
  logic [4:0]         r_bit_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_sreg;
  logic [NUM_BLK-1:0] r_wr_en;
  logic [NUM_BLK-1:0] w_onehot;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               w_hs;
  logic               w_frame_last;
  logic               w_idx_last;
  logic               w_crc_last;

  // cfg_ready is a register, so the handshake never loops back through it.
  assign w_hs         = r_ready & cfg_valid;
  assign w_frame_last = (r_bit_cnt == LAST_FRAME_BIT);
  assign w_idx_last   = (r_idx == LAST_IDX);

  // Decode the current block index into the write strobe pattern.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_BLK; k++) begin
      w_onehot[k] = (r_idx == IDX_W'(k));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_hs && w_frame_last) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_WRITE: begin
        if (w_idx_last) begin
`ifdef CFG_LOADER_CRC_EN
          w_state_nxt = ST_CRC;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef CFG_LOADER_CRC_EN
      ST_CRC: begin
        if (w_hs && w_crc_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CRC;
        end
      end
`endif
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= '0;
    end else begin
      r_ready <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_CRC);
      r_busy  <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_WRITE) ||
                 (w_state_nxt == ST_CRC);
      r_done  <= (w_state_nxt == ST_DONE);
      r_wr_en <= (w_state_nxt == ST_WRITE) ? w_onehot : '0;
    end
  end

  // Shift register, bit counter and block index; the shift register only moves on a frame handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= 5'd0;
      r_idx     <= '0;
      r_sreg    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_bit_cnt <= 5'd0;
            r_idx     <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_hs) begin
            r_sreg    <= {r_sreg[FRAME_W-2:0], cfg_data};
            r_bit_cnt <= w_frame_last ? 5'd0 : (r_bit_cnt + 5'd1);
          end
        end
        ST_WRITE: begin
          if (!w_idx_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_CRC: begin
          if (w_hs) begin
            r_bit_cnt <= w_crc_last ? 5'd0 : (r_bit_cnt + 5'd1);
          end
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
    end
  end

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] w_crc_calc;
  logic [7:0] w_crc_rx_nxt;
  logic [7:0] r_crc_rx;
  logic       r_err;
  logic       w_crc_clr;
  logic       w_crc_en;
  logic       w_crc_hs;

  assign w_crc_last   = (r_bit_cnt == LAST_CRC_BIT);
  assign w_crc_clr    = (r_state == ST_IDLE) && cfg_start;
  assign w_crc_en     = (r_state == ST_SHIFT) && w_hs;
  assign w_crc_hs     = (r_state == ST_CRC) && w_hs;
  assign w_crc_rx_nxt = {r_crc_rx[6:0], cfg_data};

  cfg_crc8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_data (cfg_data),
    .o_crc  (w_crc_calc)
  );

  // Collect the received CRC byte; compare on its last bit and keep err until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc_rx <= 8'h00;
      r_err    <= 1'b0;
    end else if (w_crc_clr) begin
      r_crc_rx <= 8'h00;
      r_err    <= 1'b0;
    end else if (w_crc_hs) begin
      r_crc_rx <= w_crc_rx_nxt;
      r_err    <= r_err | (w_crc_last && (w_crc_rx_nxt != w_crc_calc));
    end else begin
      r_crc_rx <= r_crc_rx;
      r_err    <= r_err;
    end
  end

  assign err = r_err;
`else
  assign w_crc_last = 1'b0;
  assign err        = 1'b0;
`endif

  assign cfg_ready = r_ready;
  assign bits      = r_sreg;
  assign wr_en     = r_wr_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed scoreboard bench for cfg_loader (NUM_BLK=2 and NUM_BLK=1).
// Expected writes are queued when a pass is launched and popped as wr_en pulses appear.
module tb_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sel;
  logic drv_start, drv_valid, drv_data;

  logic        d2_start, d2_valid, d2_data, d2_ready, d2_busy, d2_done, d2_err;
  logic [17:0] d2_bits;
  logic [1:0]  d2_wr;
  logic        d1_start, d1_valid, d1_data, d1_ready, d1_busy, d1_done, d1_err;
  logic [17:0] d1_bits;
  logic [0:0]  d1_wr;

  logic        obs_ready, obs_busy, obs_done, obs_err;
  logic [17:0] obs_bits;
  logic [1:0]  obs_wr;

  assign d2_start = drv_start & ~sel;
  assign d2_valid = drv_valid & ~sel;
  assign d2_data  = drv_data & ~sel;
  assign d1_start = drv_start & sel;
  assign d1_valid = drv_valid & sel;
  assign d1_data  = drv_data & sel;

  always_comb begin
    if (sel) begin
      obs_ready = d1_ready; obs_busy = d1_busy; obs_done = d1_done; obs_err = d1_err;
      obs_bits  = d1_bits;  obs_wr   = {1'b0, d1_wr};
    end else begin
      obs_ready = d2_ready; obs_busy = d2_busy; obs_done = d2_done; obs_err = d2_err;
      obs_bits  = d2_bits;  obs_wr   = d2_wr;
    end
  end

  cfg_loader #(.NUM_BLK(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_start(d2_start), .cfg_valid(d2_valid), .cfg_data(d2_data),
    .cfg_ready(d2_ready), .bits(d2_bits), .wr_en(d2_wr), .busy(d2_busy), .done(d2_done), .err(d2_err)
  );

  cfg_loader #(.NUM_BLK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_start(d1_start), .cfg_valid(d1_valid), .cfg_data(d1_data),
    .cfg_ready(d1_ready), .bits(d1_bits), .wr_en(d1_wr), .busy(d1_busy), .done(d1_done), .err(d1_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  wr;
    logic [17:0] bits;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0) over the frame bits, MSB first.
  function automatic logic [7:0] crc_model(input logic [17:0] f0, input logic [17:0] f1, input int n);
    logic [7:0]  c;
    logic [35:0] s;
    logic        b;
    c = 8'h00;
    s = {f0, f1};
    for (int i = 0; i < 18 * n; i++) begin
      b = s[35 - i];
      if (c[7] ^ b) c = {c[6:0], 1'b0} ^ 8'h07;
      else          c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic run_pass(input bit use1, input int nblk, input logic [17:0] f0, input logic [17:0] f1,
                          input bit gap, input bit poke, input bit bad, input string tag);
    logic        stream[$];
    exp_t        e;
    int          period;
    int          done_cyc;
    bit          got_done;
    logic [17:0] fr;
    logic        exp_err;
`ifdef CFG_LOADER_CRC_EN
    logic [7:0]  crc_tx;
`endif
    sel    = use1;
    period = gap ? 36 : 19;
    exp_q.delete();
    for (int k = 0; k < nblk; k++) begin
      fr = (k == 0) ? f0 : f1;
      for (int b = 17; b >= 0; b--) stream.push_back(fr[b]);
      e.cyc  = period * (k + 1);
      e.wr   = (k == 0) ? 2'b01 : 2'b10;
      e.bits = fr;
      exp_q.push_back(e);
    end
`ifdef CFG_LOADER_CRC_EN
    crc_tx = crc_model(f0, f1, nblk) ^ (bad ? 8'h01 : 8'h00);
    for (int b = 7; b >= 0; b--) stream.push_back(crc_tx[b]);
    done_cyc = gap ? (36 * nblk + 16) : (19 * nblk + 9);
    exp_err  = bad;
`else
    done_cyc = period * nblk + 1;
    exp_err  = 1'b0;
`endif
    @(negedge clk);
    cyc = 0; drv_start = 1'b1; drv_valid = 1'b0; drv_data = 1'b0;
    got_done = 1'b0;
    for (int n = 1; n <= 300 && !got_done; n++) begin
      @(negedge clk);
      cyc = n;
      if (n == 1) chk({tag, "_err_clr"}, 32'(obs_err), 32'd0);
      if (obs_wr != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_wr_extra"}, 32'(obs_wr), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_wr_cyc"}, 32'(cyc), 32'(e.cyc));
          chk({tag, "_wr_en"}, 32'(obs_wr), 32'(e.wr));
          chk({tag, "_bits"}, 32'(obs_bits), 32'(e.bits));
        end
      end
      if (obs_done) begin
        got_done = 1'b1;
        chk({tag, "_done_cyc"}, 32'(cyc), 32'(done_cyc));
        chk({tag, "_done_err"}, 32'(obs_err), 32'(exp_err));
        chk({tag, "_done_busy"}, 32'(obs_busy), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      end
      drv_start = poke && (n == 5 || n == 19);
      drv_valid = (gap ? (n % 2 == 1) : 1'b1) && (stream.size() > 0);
      drv_data  = (stream.size() > 0) ? stream[0] : 1'b0;
      if (drv_valid && obs_ready) void'(stream.pop_front());
    end
    if (!got_done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    drv_start = 1'b0; drv_valid = 1'b0; drv_data = 1'b0;
    @(negedge clk);
    chk({tag, "_post_done"}, 32'(obs_done), 32'd0);
    chk({tag, "_post_busy"}, 32'(obs_busy), 32'd0);
    chk({tag, "_post_ready"}, 32'(obs_ready), 32'd0);
    chk({tag, "_post_err"}, 32'(obs_err), 32'(exp_err));
  endtask

  initial begin
    bit seen;
    sel = 1'b0; rst_n = 1'b0;
    drv_start = 1'b0; drv_valid = 1'b0; drv_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_ready", 32'(d2_ready), 32'd0);
    chk("rst2_wr", 32'(d2_wr), 32'd0);
    chk("rst2_busy", 32'(d2_busy), 32'd0);
    chk("rst2_done", 32'(d2_done), 32'd0);
    chk("rst2_err", 32'(d2_err), 32'd0);
    chk("rst2_bits", 32'(d2_bits), 32'd0);
    chk("rst1_all", 32'({d1_ready, d1_wr, d1_busy, d1_done, d1_err, d1_bits}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(1'b0, 2, 18'h2AAAA, 18'h15555, 1'b0, 1'b0, 1'b0, "cont");
    run_pass(1'b0, 2, 18'h2AAAA, 18'h15555, 1'b1, 1'b0, 1'b0, "gap");
    run_pass(1'b0, 2, 18'h2AAAA, 18'h15555, 1'b0, 1'b1, 1'b0, "poke");

    // Reset at cycle 10 of frame 0: everything clears, no write follows.
    sel = 1'b0;
    @(negedge clk);
    drv_start = 1'b1; drv_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      drv_start = 1'b0; drv_valid = 1'b1; drv_data = n[0];
      if (n == 10) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("midrst_ready", 32'(d2_ready), 32'd0);
    chk("midrst_wr", 32'(d2_wr), 32'd0);
    chk("midrst_busy", 32'(d2_busy), 32'd0);
    chk("midrst_done", 32'(d2_done), 32'd0);
    chk("midrst_err", 32'(d2_err), 32'd0);
    chk("midrst_bits", 32'(d2_bits), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (d2_wr != 2'b00 || d2_busy) seen = 1'b1;
    end
    chk("midrst_nowrite", 32'(seen), 32'd0);
    drv_valid = 1'b0; drv_data = 1'b0;

    run_pass(1'b0, 2, 18'h15555, 18'h2AAAA, 1'b0, 1'b0, 1'b0, "post_rst");
    run_pass(1'b1, 1, 18'h3C0F5, 18'h00000, 1'b0, 1'b0, 1'b0, "blk1");

`ifdef CFG_LOADER_CRC_EN
    run_pass(1'b1, 1, 18'h00000, 18'h00000, 1'b0, 1'b0, 1'b0, "crc_ok");
    run_pass(1'b1, 1, 18'h00000, 18'h00000, 1'b0, 1'b0, 1'b1, "crc_bad");
    repeat (5) @(negedge clk);
    chk("crc_sticky", 32'(d1_err), 32'd1);
    run_pass(1'b1, 1, 18'h00000, 18'h00000, 1'b0, 1'b0, 1'b0, "crc_clr");
    run_pass(1'b0, 2, 18'h2AAAA, 18'h15555, 1'b1, 1'b0, 1'b1, "crc_gap_bad");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
